// File: rtl/wb_stage_pkg.sv
// Shared defaults and payload typedef for the writeback stage.
// Holds no logic; imported by wb_stage and wb_fifo.
package wb_stage_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ROB_SIZE      = 4;
    localparam int DEF_DEST_REG_SIZE = 3;
    localparam int DEF_CTRL_WIDTH    = 6;

    // ctrl value the execute arbiter emits on cycles with no real result
    localparam logic [DEF_CTRL_WIDTH-1:0] CTRL_IDLE = '0;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]    data;
        logic                         pred;
        logic [DEF_CTRL_WIDTH-1:0]    ctrl;
        logic [DEF_DEST_REG_SIZE-1:0] dest;
        logic [DEF_ROB_SIZE-1:0]      rob_entry;
    } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer: DEPTH entries, power-of-two pointers wrapping naturally.
// Latency: written entry visible at head one cycle after push.
// Backpressure: push ignored when full, pop ignored when empty; clear empties it.
module wb_fifo
    import wb_stage_pkg::*;
#(
    parameter int WIDTH = $bits(wb_entry),
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full      = (occupancy == (AW+1)'(DEPTH));
    assign empty     = (occupancy == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // storage needs no reset: unread slots are never visible outside wb_stage
    always_ff @(posedge clk) begin
        if (do_push && !clear && !reset) mem[tail] <= push_data;
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: filters idle results, buffers them in order for the ROB.
// Latency: 1 cycle via FIFO; 0 cycles when WB_BYPASS_EN is defined and the buffer is empty.
// Backpressure: ex_ready = buffer not full (registered); payload held while rob_wr_ready low.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ROB_SIZE      = DEF_ROB_SIZE,
    parameter int DEST_REG_SIZE = DEF_DEST_REG_SIZE,
    parameter int CTRL_WIDTH    = DEF_CTRL_WIDTH,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     ex_valid,
    input  logic [DATA_WIDTH-1:0]    ex_data,
    input  logic                     ex_pred,
    input  logic [CTRL_WIDTH-1:0]    ex_ctrl,
    input  logic [DEST_REG_SIZE-1:0] ex_dest_reg,
    input  logic [ROB_SIZE-1:0]      ex_rob_entry,
    output logic                     ex_ready,
    output logic                     rob_wr_valid,
    input  logic                     rob_wr_ready,
    output logic [DATA_WIDTH-1:0]    rob_wr_data,
    output logic                     rob_wr_pred,
    output logic [CTRL_WIDTH-1:0]    rob_wr_ctrl,
    output logic [DEST_REG_SIZE-1:0] rob_wr_dest,
    output logic [ROB_SIZE-1:0]      rob_wr_entry,
    output logic [$clog2(DEPTH):0]   occupancy
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic                     pred;
        logic [CTRL_WIDTH-1:0]    ctrl;
        logic [DEST_REG_SIZE-1:0] dest;
        logic [ROB_SIZE-1:0]      rob_entry;
    } entry_t;

    entry_t ex_entry;
    entry_t head_entry;
    entry_t out_entry;
    logic   is_work;
    logic   bypass;
    logic   push;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;

    assign ex_entry = '{data: ex_data, pred: ex_pred, ctrl: ex_ctrl,
                        dest: ex_dest_reg, rob_entry: ex_rob_entry};

    assign is_work  = ex_valid && (ex_ctrl != CTRL_WIDTH'(CTRL_IDLE));
    assign ex_ready = !fifo_full;

`ifdef WB_BYPASS_EN
    assign bypass = fifo_empty && is_work && !flush;
`else
    assign bypass = 1'b0;
`endif

    // a bypassed result the ROB takes this cycle must not also be buffered
    assign push = is_work && ex_ready && !flush && !(bypass && rob_wr_ready);
    assign pop  = !fifo_empty && rob_wr_ready;

    wb_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data (ex_entry),
        .pop       (pop),
        .head_data (head_entry),
        .occupancy (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rob_wr_valid = !fifo_empty || bypass;

    // payload reads zero whenever nothing is offered, including straight after reset
    always_comb begin
        out_entry = '0;
        if (!fifo_empty) begin
            out_entry = head_entry;
        end else if (bypass) begin
            out_entry = ex_entry;
        end
    end

    assign rob_wr_data  = out_entry.data;
    assign rob_wr_pred  = out_entry.pred;
    assign rob_wr_ctrl  = out_entry.ctrl;
    assign rob_wr_dest  = out_entry.dest;
    assign rob_wr_entry = out_entry.rob_entry;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed vectors, one checking task.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_data;
    logic        ex_pred;
    logic [5:0]  ex_ctrl;
    logic [2:0]  ex_dest_reg;
    logic [3:0]  ex_rob_entry;
    logic        ex_ready;
    logic        rob_wr_valid;
    logic        rob_wr_ready;
    logic [31:0] rob_wr_data;
    logic        rob_wr_pred;
    logic [5:0]  rob_wr_ctrl;
    logic [2:0]  rob_wr_dest;
    logic [3:0]  rob_wr_entry;
    logic [2:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_data      (ex_data),
        .ex_pred      (ex_pred),
        .ex_ctrl      (ex_ctrl),
        .ex_dest_reg  (ex_dest_reg),
        .ex_rob_entry (ex_rob_entry),
        .ex_ready     (ex_ready),
        .rob_wr_valid (rob_wr_valid),
        .rob_wr_ready (rob_wr_ready),
        .rob_wr_data  (rob_wr_data),
        .rob_wr_pred  (rob_wr_pred),
        .rob_wr_ctrl  (rob_wr_ctrl),
        .rob_wr_dest  (rob_wr_dest),
        .rob_wr_entry (rob_wr_entry),
        .occupancy    (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // inputs change 1ns after the rising edge; checks happen mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [5:0] c,
                         input logic [3:0] r);
        ex_valid     = v;
        ex_data      = d;
        ex_ctrl      = c;
        ex_rob_entry = r;
        ex_dest_reg  = r[2:0];
        ex_pred      = r[0];
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        rob_wr_ready = 1'b0;
        drive(1'b0, 32'h0, 6'h0, 4'h0);
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("rst_occ",   occupancy,    3'd0);
        chk("rst_valid", rob_wr_valid, 1'b0);
        chk("rst_ready", ex_ready,     1'b1);
        chk("rst_data",  rob_wr_data,  32'h0);

        // single result, ROB ready
        rob_wr_ready = 1'b1;
        drive(1'b1, 32'h1234, 6'h0B, 4'd5);
        settle();
`ifdef WB_BYPASS_EN
        chk("byp_valid_n", rob_wr_valid, 1'b1);
        chk("byp_data_n",  rob_wr_data,  32'h1234);
        tick();
        drive(1'b0, 32'h0, 6'h0, 4'h0);
        settle();
        chk("byp_occ", occupancy, 3'd0);
`else
        chk("lat_valid_n", rob_wr_valid, 1'b0);
        tick();
        drive(1'b0, 32'h0, 6'h0, 4'h0);
        settle();
        chk("lat_valid_n1", rob_wr_valid, 1'b1);
        chk("lat_data",     rob_wr_data,  32'h1234);
        chk("lat_ctrl",     rob_wr_ctrl,  6'h0B);
        chk("lat_entry",    rob_wr_entry, 4'd5);
        chk("lat_dest",     rob_wr_dest,  3'd5);
        chk("lat_pred",     rob_wr_pred,  1'b1);
        tick();
        settle();
        chk("lat_drained", occupancy, 3'd0);
`endif

        // idle-arbiter cycles are dropped
        rob_wr_ready = 1'b0;
        drive(1'b1, 32'hDEAD, 6'h0, 4'd1);
        tick();
        tick();
        settle();
        chk("idle_occ",   occupancy,    3'd0);
        chk("idle_valid", rob_wr_valid, 1'b0);

        // fill to capacity, fifth push ignored, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA0 + i, 6'(i + 1), 4'(i));
            tick();
        end
        settle();
        chk("full_occ",   occupancy, 3'd4);
        chk("full_ready", ex_ready,  1'b0);
        drive(1'b1, 32'hEE, 6'h5, 4'd9);
        tick();
        settle();
        chk("full_5th_occ", occupancy,   3'd4);
        chk("full_head",    rob_wr_data, 32'hA0);
        drive(1'b0, 32'h0, 6'h0, 4'h0);
        rob_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_valid", rob_wr_valid, 1'b1);
            chk("drain_data",  rob_wr_data,  32'hA0 + i);
            chk("drain_entry", rob_wr_entry, 4'(i));
            tick();
        end
        settle();
        chk("drain_empty", rob_wr_valid, 1'b0);

        // occupancy 2, push+pop together across pointer wrap
        rob_wr_ready = 1'b0;
        drive(1'b1, 32'hB0, 6'h1, 4'd0);
        tick();
        drive(1'b1, 32'hB1, 6'h2, 4'd1);
        tick();
        settle();
        chk("pp_occ_init", occupancy, 3'd2);
        rob_wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hB2 + i, 6'h3, 4'(i + 2));
            settle();
            chk("pp_head", rob_wr_data, 32'hB0 + i);
            tick();
            settle();
            chk("pp_occ", occupancy, 3'd2);
        end
        drive(1'b0, 32'h0, 6'h0, 4'h0);
        for (int i = 3; i < 5; i++) begin
            settle();
            chk("pp_tail", rob_wr_data, 32'hB0 + i);
            tick();
        end
        settle();
        chk("pp_empty", occupancy, 3'd0);

        // flush at occupancy 3 with a concurrent push
        rob_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC0 + i, 6'h7, 4'(i));
            tick();
        end
        flush = 1'b1;
        drive(1'b1, 32'hC3, 6'h1, 4'd3);
        settle();
        chk("fl_pre_occ",   occupancy,    3'd3);
        chk("fl_pre_valid", rob_wr_valid, 1'b1);
        chk("fl_pre_data",  rob_wr_data,  32'hC0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 6'h0, 4'h0);
        settle();
        chk("fl_occ",   occupancy,    3'd0);
        chk("fl_valid", rob_wr_valid, 1'b0);
        tick();
        settle();
        chk("fl_discard", occupancy, 3'd0);

        // reset with two entries buffered
        drive(1'b1, 32'hD0, 6'h2, 4'd6);
        tick();
        drive(1'b1, 32'hD1, 6'h2, 4'd7);
        tick();
        drive(1'b0, 32'h0, 6'h0, 4'h0);
        settle();
        chk("rs_occ_pre", occupancy, 3'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rs_occ",   occupancy,    3'd0);
        chk("rs_valid", rob_wr_valid, 1'b0);
        chk("rs_ready", ex_ready,     1'b1);
        chk("rs_data",  rob_wr_data,  32'h0);
        chk("rs_entry", rob_wr_entry, 4'h0);
        chk("rs_ctrl",  rob_wr_ctrl,  6'h0);

        // pointers restart cleanly after reset
        drive(1'b1, 32'hE1, 6'h3, 4'd2);
        tick();
        drive(1'b0, 32'h0, 6'h0, 4'h0);
        settle();
        chk("post_rs_occ",  occupancy,   3'd1);
        chk("post_rs_data", rob_wr_data, 32'hE1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
